// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO write-side blocks.
package fifo_pkg;

    localparam int DATA_W = 32;
    typedef logic [DATA_W-1:0] data_t;

    localparam int N_REQ_DEF     = 4;
    localparam int MAX_BURST_DEF = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = ST_IDLE,
        GRANT = ST_GRANT
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted valid bit found when
// scanning start, start+1, ... modulo N_REQ.
module rr_pick
    import fifo_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0]         valid,
    input  logic [$clog2(N_REQ)-1:0] start,
    output logic                     found,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int IW = $clog2(N_REQ);
    localparam int PW = IW + 1;

    logic [PW-1:0] pos;

    // Scan from the farthest offset down so the nearest valid offset wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            pos = {1'b0, start} + PW'(i);
            if (pos >= PW'(N_REQ)) begin
                pos = pos - PW'(N_REQ);
            end
            if (valid[pos[IW-1:0]]) begin
                found = 1'b1;
                idx   = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO push port among N_REQ producers.
// A grant lasts up to MAX_BURST pushes; on release the next owner is picked
// in the same cycle so handoffs cost no bubble.
//
// state | meaning
// IDLE  | no owner; one arbitration cycle before the first grant
// GRANT | gnt_id owns the push port; FIFO full stalls without releasing
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                       wr_clk,
    input  logic                       wr_rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  data_t [N_REQ-1:0]          req_data,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_push,
    output data_t                      fifo_data,
    output logic                       gnt_valid,
    output logic [$clog2(N_REQ)-1:0]   gnt_id
);

    localparam int IW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_e      state;
    logic [IW-1:0]   rr_ptr;
    logic [BW-1:0]   burst_cnt;
    logic [IW-1:0]   next_id;
    logic [IW-1:0]   pick_start;
    logic [IW-1:0]   pick_idx;
    logic            pick_found;
    logic            granted;
    logic            cur_valid;
    logic            rel;

    assign granted   = (state == GRANT);
    assign cur_valid = req_valid[gnt_id];
    assign next_id   = (gnt_id == IW'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;

    // On release the current owner becomes last in the scan order.
    assign pick_start = granted ? next_id : rr_ptr;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .valid (req_valid),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Full freezes the grant: no push and no release until it clears.
    assign rel = granted && !fifo_full &&
                 (!cur_valid || (burst_cnt == BW'(MAX_BURST - 1)));

    assign fifo_push = granted && cur_valid && !fifo_full && !wr_rst;
    assign fifo_data = req_data[gnt_id];
    assign gnt_valid = granted;

    // Only the owner sees ready, and never while full or in reset.
    always_comb begin
        req_ready = '0;
        if (granted && !fifo_full && !wr_rst) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    // Grant state machine, rotation pointer and burst counter.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state     <= IDLE;
            gnt_id    <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt_id    <= pick_idx;
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        rr_ptr    <= next_id;
                        burst_cnt <= '0;
                        if (pick_found) begin
                            gnt_id <= pick_idx;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (fifo_push) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-side arbiter that shares the single push port of fifo_top among N_REQ producers.
- Lives in the write clock domain, in front of the FIFO's push/data_in/full signals.
- Grants one producer at a time for a bounded burst, then rotates the grant.
- Passes FIFO back-pressure (full) to the granted producer through a valid/ready handshake.

Parameters:
N_REQ, 4, number of requesters (2..16).
MAX_BURST, 8, maximum words pushed per grant before a forced rotation (>=1).

Ports:
wr_clk  in  1  write-domain clock; the block's only clock.
wr_rst  in  1  synchronous, active-high reset.
req_valid  in  N_REQ  per-requester word-valid.
req_data  in  N_REQ x data_t  per-requester write word.
req_ready  out  N_REQ  per-requester accept; a word transfers when valid&ready.
fifo_full  in  1  FIFO full flag.
fifo_push  out  1  FIFO push strobe.
fifo_data  out  data_t  FIFO write word.
gnt_valid  out  1  a grant is currently held.
gnt_id  out  $clog2(N_REQ)  index of the granted requester.

Behaviour:
- Interface decision: one clock, wr_clk; reset wr_rst is synchronous and active-high.
- Reset values:
  - state=IDLE, gnt_id=0, rr_ptr=0, burst_cnt=0.
  - fifo_push=0, req_ready=0, gnt_valid=0.
  - fifo_push and req_ready are forced to 0 in every cycle wr_rst is high, whatever the state.
- Registered state: state {IDLE, GRANT}, gnt_id, rr_ptr (search start), burst_cnt of width $clog2(MAX_BURST+1).
- Round-robin pick (combinational):
  - Returns the first asserted req_valid scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - Returns "none" when no req_valid is asserted.
- IDLE:
  - No pushes.
  - If the pick is found: gnt_id<=pick, burst_cnt<=0, go to GRANT. This costs one arbitration cycle.
- GRANT:
  - gnt_valid=1.
  - req_ready[gnt_id] = ~fifo_full; all other req_ready=0.
  - fifo_push = req_valid[gnt_id] & ~fifo_full.
  - fifo_data = req_data[gnt_id], combinational, zero latency.
  - On each push, burst_cnt increments.
- Release condition (in GRANT), either of:
  - (a) a push occurs while burst_cnt==MAX_BURST-1;
  - (b) req_valid[gnt_id]==0 while ~fifo_full.
- On release:
  - rr_ptr <= gnt_id+1 mod N_REQ.
  - Pick again in the same cycle, using the current req_valid and scanning from gnt_id+1.
  - If found: regrant directly with no bubble, burst_cnt<=0, stay in GRANT. The current requester is last in the scan order, so it is regranted only if it is the only one valid.
  - If none: go to IDLE.
- fifo_full in GRANT:
  - Holds gnt_id and burst_cnt; no push, no release.
  - The stall is unbounded.
  - Valid going low during full is not evaluated until full deasserts.
- Requester rule: once req_valid is high, req_data is held stable until the transfer. The arbiter does not check this.
- No word is ever dropped or duplicated; pushes never occur while fifo_full=1.
- Reset mid-burst: the grant is abandoned, the word presented in that cycle is not pushed, and the next pick starts at requester 0.

Decomposition:
- fifo_pkg additions:
  - constant N_REQ_DEF=4, MAX_BURST_DEF=8;
  - typedef arb_state_e {IDLE, GRANT};
  - reuse of the existing data_t.
- Sub-module rr_pick: purely combinational, parameterised by N_REQ.
  - Inputs: valid vector, start pointer.
  - Outputs: found, index.
  - Instantiated once and fed the IDLE or release-time start pointer.

Test Plan:
1. Only req 0 valid with 20 words, MAX_BURST=8, FIFO never full -> cycle 0 is IDLE; words pushed on cycles 1..20 with no bubble at the 8- and 16-word regrants; gnt_id=0 throughout.
2. All 4 requesters valid continuously, data tagged {id,seq} -> fifo_data order is 8 words each of id 0,1,2,3,0,...; handoffs add no idle cycles.
3. Req 1 granted, drops valid after 3 words while req 2 valid -> the release cycle has no push; the next cycle pushes req 2's word 0; rr_ptr=2.
4. fifo_full high for 5 cycles after the 4th word of a burst -> fifo_push=0 and req_ready=0 for 5 cycles; gnt_id and burst_cnt=4 held; exactly 4 more words complete the burst.
5. wr_rst pulsed for 1 cycle mid-burst on req 2 -> no push in the reset cycle; IDLE the next cycle; the next grant goes to the lowest-index valid requester.
6. MAX_BURST=1, reqs 0 and 3 valid -> pushes alternate 0,3,0,3 every cycle after the first IDLE cycle.
